// File: rtl/cbfp_pkg.sv
// -----------------------------------------------------------------------------
// cbfp_pkg
// Shared constants, types and helpers for the CBFP (convergent block floating
// point) datapath. Imported by both the exponent detector and the downstream
// shift/saturate stage so that both agree on sample and shift-amount widths.
//   IN_WIDTH    : signed sample width
//   DATA_NUM    : samples per beat on each rail
//   SHIFT_WIDTH : shift amount width (holds IN_WIDTH-1)
//   SHIFT_POLE  : nominal shift pole used by the shifter stage
// -----------------------------------------------------------------------------
package cbfp_pkg;

  localparam int IN_WIDTH    = 23;
  localparam int DATA_NUM    = 16;
  localparam int SHIFT_WIDTH = 5;
  localparam int SHIFT_POLE  = 12;

  typedef logic signed [IN_WIDTH-1:0] sample_t;
  typedef logic [SHIFT_WIDTH-1:0]     shamt_t;

  // Smaller of two redundant-sign-bit counts.
  function automatic shamt_t min_shamt(input shamt_t a, input shamt_t b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/cbfp_lsc.sv
// -----------------------------------------------------------------------------
// cbfp_lsc
// Combinational leading-sign counter: number of bits directly below the MSB
// that equal the MSB (redundant sign bits). Result range 0..IN_WIDTH-1.
// Ports:
//   i_sample : signed input sample
//   o_lsc    : redundant sign-bit count
// -----------------------------------------------------------------------------
module cbfp_lsc
  import cbfp_pkg::*;
(
  input  sample_t i_sample,
  output shamt_t  o_lsc
);

  shamt_t w_cnt;
  logic   w_run;

  // Walk down from MSB-1 while bits still match the sign; stop at the first difference.
  always_comb begin
    w_cnt = {SHIFT_WIDTH{1'b0}};
    w_run = 1'b1;
    for (int i = IN_WIDTH - 2; i >= 0; i--) begin
      if (w_run && (i_sample[i] == i_sample[IN_WIDTH-1])) begin
        w_cnt = w_cnt + shamt_t'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  assign o_lsc = w_cnt;

endmodule

// File: rtl/cbfp_exp_detect.sv
// -----------------------------------------------------------------------------
// cbfp_exp_detect
// Block-exponent detector and aligning buffer. Finds the minimum redundant
// sign-bit count per CBFP block (separately for real and imaginary rails),
// buffers the block in a ping-pong store, and replays it as BLK_BEATS
// contiguous beats carrying constant shift amounts for the whole block.
//
// Optional feature macro: CBFP_EXP_LOG_EN
//   When defined, adds exp_log_valid / exp_log = {blk_idx[15:0], re, im},
//   pulsed together with out_first, for later denormalisation.
//
// Ports:
//   clk, rstn               : clock (rising edge), async active-low reset
//   in_valid                : input beat valid (gaps allowed)
//   in_real / in_imag       : DATA_NUM signed samples per rail
//   out_valid               : replayed beat valid
//   out_real / out_imag     : replayed samples (hold when out_valid=0)
//   shift_amt_re / _im      : block minimum sign-bit count per rail
//   out_first               : beat 0 of a replayed block
//   exp_log_valid, exp_log  : (CBFP_EXP_LOG_EN only) per-block exponent log
// -----------------------------------------------------------------------------
module cbfp_exp_detect
  import cbfp_pkg::*;
#(
  parameter int BLK_BEATS = 4
)
(
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               in_valid,
  input  logic [DATA_NUM-1:0][IN_WIDTH-1:0]  in_real,
  input  logic [DATA_NUM-1:0][IN_WIDTH-1:0]  in_imag,
  output logic                               out_valid,
  output logic [DATA_NUM-1:0][IN_WIDTH-1:0]  out_real,
  output logic [DATA_NUM-1:0][IN_WIDTH-1:0]  out_imag,
  output shamt_t                             shift_amt_re,
  output shamt_t                             shift_amt_im,
  output logic                               out_first
`ifdef CBFP_EXP_LOG_EN
  ,
  output logic                               exp_log_valid,
  output logic [2*SHIFT_WIDTH+15:0]          exp_log
`endif
);

  localparam int                 CNT_W     = $clog2(BLK_BEATS);
  localparam int                 RAIL_W    = DATA_NUM * IN_WIDTH;
  localparam int                 BEAT_W    = 2 * RAIL_W;
  localparam shamt_t             SHAMT_MAX = shamt_t'(IN_WIDTH - 1);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BLK_BEATS - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};

  // ---------------------------------------------------------------------------
  // Per-sample sign counts and per-beat minima
  // ---------------------------------------------------------------------------
  shamt_t w_lsc_re [DATA_NUM];
  shamt_t w_lsc_im [DATA_NUM];
  shamt_t w_beat_min_re;
  shamt_t w_beat_min_im;

  for (genvar g = 0; g < DATA_NUM; g++) begin : g_lsc
    cbfp_lsc u_lsc_re (.i_sample(in_real[g]), .o_lsc(w_lsc_re[g]));
    cbfp_lsc u_lsc_im (.i_sample(in_imag[g]), .o_lsc(w_lsc_im[g]));
  end

  // Reduce the DATA_NUM per-sample counts of each rail to one beat minimum.
  always_comb begin
    w_beat_min_re = SHAMT_MAX;
    w_beat_min_im = SHAMT_MAX;
    for (int i = 0; i < DATA_NUM; i++) begin
      w_beat_min_re = min_shamt(w_beat_min_re, w_lsc_re[i]);
      w_beat_min_im = min_shamt(w_beat_min_im, w_lsc_im[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Write side: beat counter, block minima, bank select
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_wr_bank;
  shamt_t           r_blk_min_re;
  shamt_t           r_blk_min_im;
  shamt_t           r_exp_re;
  shamt_t           r_exp_im;
  shamt_t           w_blk_min_re;
  shamt_t           w_blk_min_im;
  logic             w_last_beat;

  assign w_last_beat = in_valid && (r_beat_cnt == LAST_BEAT);

  // Running block minimum including the current beat; beat 0 restarts the block.
  always_comb begin
    if (r_beat_cnt == CNT_ZERO) begin
      w_blk_min_re = w_beat_min_re;
      w_blk_min_im = w_beat_min_im;
    end else begin
      w_blk_min_re = min_shamt(r_blk_min_re, w_beat_min_re);
      w_blk_min_im = min_shamt(r_blk_min_im, w_beat_min_im);
    end
  end

  // Beat counting, minimum accumulation and hand-off of the finished block's exponents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat_cnt   <= CNT_ZERO;
      r_wr_bank    <= 1'b0;
      r_blk_min_re <= SHAMT_MAX;
      r_blk_min_im <= SHAMT_MAX;
      r_exp_re     <= SHAMT_MAX;
      r_exp_im     <= SHAMT_MAX;
    end else if (in_valid) begin
      r_beat_cnt   <= r_beat_cnt + CNT_W'(1);
      r_blk_min_re <= w_blk_min_re;
      r_blk_min_im <= w_blk_min_im;
      if (w_last_beat) begin
        r_wr_bank <= ~r_wr_bank;
        r_exp_re  <= w_blk_min_re;
        r_exp_im  <= w_blk_min_im;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ping-pong beat store, addressed as {bank, beat}
  // ---------------------------------------------------------------------------
  logic [BEAT_W-1:0] r_mem [2*BLK_BEATS];

  // Capture each valid input beat into the current write bank (storage only, no reset).
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_mem[{r_wr_bank, r_beat_cnt}] <= {in_real, in_imag};
    end
  end

  // ---------------------------------------------------------------------------
  // Replay control
  // ---------------------------------------------------------------------------
  logic             r_rd_active;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             r_rd_bank;
  logic [BEAT_W-1:0] w_rd_beat;
  logic             w_rd_start;

  assign w_rd_beat  = r_mem[{r_rd_bank, r_rd_cnt}];
  assign w_rd_start = r_rd_active && (r_rd_cnt == CNT_ZERO);

  // A completed block always (re)starts replay; this wins over the end of the
  // previous replay so back-to-back blocks stream without a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_active <= 1'b0;
      r_rd_cnt    <= CNT_ZERO;
      r_rd_bank   <= 1'b0;
    end else if (w_last_beat) begin
      r_rd_active <= 1'b1;
      r_rd_cnt    <= CNT_ZERO;
      r_rd_bank   <= r_wr_bank;
    end else if (r_rd_active) begin
      r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (r_rd_cnt == LAST_BEAT) begin
        r_rd_active <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // Emit replayed beats; shift amounts change only at the start of a block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid    <= 1'b0;
      out_first    <= 1'b0;
      out_real     <= {RAIL_W{1'b0}};
      out_imag     <= {RAIL_W{1'b0}};
      shift_amt_re <= SHAMT_MAX;
      shift_amt_im <= SHAMT_MAX;
    end else begin
      out_valid <= r_rd_active;
      out_first <= w_rd_start;
      if (r_rd_active) begin
        out_real <= w_rd_beat[BEAT_W-1 -: RAIL_W];
        out_imag <= w_rd_beat[RAIL_W-1:0];
      end
      if (w_rd_start) begin
        shift_amt_re <= r_exp_re;
        shift_amt_im <= r_exp_im;
      end
    end
  end

`ifdef CBFP_EXP_LOG_EN
  logic [15:0] r_blk_idx;

  // Per-block exponent log with a wrapping block index, aligned with out_first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_blk_idx     <= 16'd0;
      exp_log_valid <= 1'b0;
      exp_log       <= {(2*SHIFT_WIDTH+16){1'b0}};
    end else begin
      exp_log_valid <= w_rd_start;
      if (w_rd_start) begin
        exp_log   <= {r_blk_idx, r_exp_re, r_exp_im};
        r_blk_idx <= r_blk_idx + 16'd1;
      end
    end
  end
`endif

endmodule
